// File: rtl/exu_wb_skid_buffer_if.sv
// Handshake bundle between the execute stage, the result skid buffer and write-back.
// master: the pipeline side that drives inputs and out_ready.
// slave:  the buffer itself.
interface exu_wb_skid_buffer_if #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned RD_W   = 5
);
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_res;
    logic [DATA_W-1:0] in_pc;
    logic [RD_W-1:0]   in_rd;
    logic              in_wen;

    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_res;
    logic [DATA_W-1:0] out_pc;
    logic [RD_W-1:0]   out_rd;
    logic              out_wen;
    logic [1:0]        out_count;

    modport master (
        output in_valid, in_res, in_pc, in_rd, in_wen, out_ready,
        input  in_ready, out_valid, out_res, out_pc, out_rd, out_wen, out_count
    );

    modport slave (
        input  in_valid, in_res, in_pc, in_rd, in_wen, out_ready,
        output in_ready, out_valid, out_res, out_pc, out_rd, out_wen, out_count
    );
endinterface

// File: rtl/exu_wb_skid_buffer.sv
// Two-entry elastic buffer between the execute ALU and write-back.
// Head (main) register drives out_*; the skid register absorbs one extra result
// so in_ready never depends combinationally on out_ready.
module exu_wb_skid_buffer #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned RD_W   = 5
) (
    input  logic                 clock,
    input  logic                 rst_n,
    input  logic                 flush,
    exu_wb_skid_buffer_if.slave  bus
);

    typedef enum logic [1:0] {
        StEmpty = 2'd0,
        StOne   = 2'd1,
        StFull  = 2'd2
    } state_e;

    state_e r_state;
    state_e w_state_next;

    logic [DATA_W-1:0] r_main_res, r_main_pc, r_skid_res, r_skid_pc;
    logic [RD_W-1:0]   r_main_rd, r_skid_rd;
    logic              r_main_wen, r_skid_wen;

    logic w_in_fire;
    logic w_out_fire;
    logic w_load_main_in;
    logic w_load_main_skid;
    logic w_load_skid;
    logic w_in_wen;

    // Writes to x0 are architecturally dead; drop the write request at capture.
    assign w_in_wen = bus.in_wen & (bus.in_rd != '0);

    // State register.
    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= StEmpty;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next state and load strobes; flush overrides every handshake.
    always_comb begin
        w_state_next     = r_state;
        w_load_main_in   = 1'b0;
        w_load_main_skid = 1'b0;
        w_load_skid      = 1'b0;
        w_in_fire        = bus.in_valid & (r_state != StFull);
        w_out_fire       = bus.out_ready & (r_state != StEmpty);
        if (flush) begin
            w_state_next = StEmpty;
        end else begin
            case (r_state)
                StEmpty: begin
                    if (w_in_fire) begin
                        w_load_main_in = 1'b1;
                        w_state_next   = StOne;
                    end
                end
                StOne: begin
                    if (w_in_fire && w_out_fire) begin
                        w_load_main_in = 1'b1;
                    end else if (w_in_fire) begin
                        w_load_skid  = 1'b1;
                        w_state_next = StFull;
                    end else if (w_out_fire) begin
                        w_state_next = StEmpty;
                    end
                end
                StFull: begin
                    if (w_out_fire) begin
                        w_load_main_skid = 1'b1;
                        w_state_next     = StOne;
                    end
                end
                default: w_state_next = StEmpty;
            endcase
        end
    end

    // Head register: loads from the input or promotes the skid entry.
    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            r_main_res <= '0;
            r_main_pc  <= '0;
            r_main_rd  <= '0;
            r_main_wen <= 1'b0;
        end else if (w_load_main_in) begin
            r_main_res <= bus.in_res;
            r_main_pc  <= bus.in_pc;
            r_main_rd  <= bus.in_rd;
            r_main_wen <= w_in_wen;
        end else if (w_load_main_skid) begin
            r_main_res <= r_skid_res;
            r_main_pc  <= r_skid_pc;
            r_main_rd  <= r_skid_rd;
            r_main_wen <= r_skid_wen;
        end
    end

    // Skid register: only written when the head is stalled and a second result arrives.
    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            r_skid_res <= '0;
            r_skid_pc  <= '0;
            r_skid_rd  <= '0;
            r_skid_wen <= 1'b0;
        end else if (w_load_skid) begin
            r_skid_res <= bus.in_res;
            r_skid_pc  <= bus.in_pc;
            r_skid_rd  <= bus.in_rd;
            r_skid_wen <= w_in_wen;
        end
    end

    // Outputs decoded from registered state only.
    always_comb begin
        bus.in_ready  = (r_state != StFull);
        bus.out_valid = (r_state != StEmpty);
        bus.out_res   = r_main_res;
        bus.out_pc    = r_main_pc;
        bus.out_rd    = r_main_rd;
        bus.out_wen   = r_main_wen;
        bus.out_count = 2'd0;
        if (r_state == StOne) begin
            bus.out_count = 2'd1;
        end else if (r_state == StFull) begin
            bus.out_count = 2'd2;
        end
    end

endmodule

// File: tb/tb_exu_wb_skid_buffer.sv
// Directed and random checks for exu_wb_skid_buffer.
module tb_exu_wb_skid_buffer;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned RD_W   = 5;

    typedef struct packed {
        logic [DATA_W-1:0] res;
        logic [DATA_W-1:0] pc;
        logic [RD_W-1:0]   rd;
        logic              wen;
    } ent_t;

    logic clock;
    logic rst_n;
    logic flush;

    int n_vec;
    int n_err;

    ent_t q[$];

    exu_wb_skid_buffer_if #(.DATA_W(DATA_W), .RD_W(RD_W)) bus ();

    exu_wb_skid_buffer #(.DATA_W(DATA_W), .RD_W(RD_W)) dut (
        .clock (clock),
        .rst_n (rst_n),
        .flush (flush),
        .bus   (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic drive(input logic v, input logic [DATA_W-1:0] res,
                         input logic [DATA_W-1:0] pc, input logic [RD_W-1:0] rd,
                         input logic wen);
        bus.in_valid = v;
        bus.in_res   = res;
        bus.in_pc    = pc;
        bus.in_rd    = rd;
        bus.in_wen   = wen;
    endtask

    task automatic chk_stat(input string tag, input logic v, input logic [1:0] c, input logic r);
        check(tag, 128'({bus.out_valid, bus.out_count, bus.in_ready}), 128'({v, c, r}));
    endtask

    task automatic chk_head(input string tag, input logic [DATA_W-1:0] res,
                            input logic [DATA_W-1:0] pc, input logic [RD_W-1:0] rd,
                            input logic wen);
        check(tag, 128'({bus.out_res, bus.out_pc, bus.out_rd, bus.out_wen}),
              128'({res, pc, rd, wen}));
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        flush = 1'b0;
        bus.out_ready = 1'b0;
        drive(1'b0, '0, '0, '0, 1'b0);
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        #2;
        chk_stat("rst_stat", 1'b0, 2'd0, 1'b1);
        chk_head("rst_head", 32'h0, 32'h0, 5'd0, 1'b0);
        @(negedge clock);
        rst_n = 1'b1;

        // Single push then a back-to-back stream
        drive(1'b1, 32'h0000_0010, 32'h8000_0000, 5'd5, 1'b1);
        bus.out_ready = 1'b1;
        step();
        chk_stat("s1_stat", 1'b1, 2'd1, 1'b1);
        chk_head("s1_head", 32'h0000_0010, 32'h8000_0000, 5'd5, 1'b1);
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, 32'h20 + 32'(i), 32'h8000_0004 + 32'(4 * i), 5'(i + 1), 1'b1);
            step();
            chk_head("s1_stream", 32'h20 + 32'(i), 32'h8000_0004 + 32'(4 * i), 5'(i + 1), 1'b1);
            chk_stat("s1_stream_stat", 1'b1, 2'd1, 1'b1);
        end
        drive(1'b0, '0, '0, '0, 1'b0);
        step();
        chk_stat("s1_drain", 1'b0, 2'd0, 1'b1);
        chk_head("s1_hold", 32'h27, 32'h8000_0020, 5'd8, 1'b1);

        // Fill while stalled, then release
        bus.out_ready = 1'b0;
        drive(1'b1, 32'hA, 32'h100, 5'd1, 1'b1);
        step();
        chk_stat("s2_a_stat", 1'b1, 2'd1, 1'b1);
        chk_head("s2_a_head", 32'hA, 32'h100, 5'd1, 1'b1);
        drive(1'b1, 32'hB, 32'h104, 5'd2, 1'b1);
        step();
        chk_stat("s2_full", 1'b1, 2'd2, 1'b0);
        chk_head("s2_stall_a", 32'hA, 32'h100, 5'd1, 1'b1);
        drive(1'b1, 32'hC, 32'h108, 5'd3, 1'b1);
        step();
        chk_stat("s2_c_refused", 1'b1, 2'd2, 1'b0);
        chk_head("s2_stall_a2", 32'hA, 32'h100, 5'd1, 1'b1);
        bus.out_ready = 1'b1;
        step();
        chk_head("s2_b", 32'hB, 32'h104, 5'd2, 1'b1);
        chk_stat("s2_b_stat", 1'b1, 2'd1, 1'b1);
        step();
        chk_head("s2_c", 32'hC, 32'h108, 5'd3, 1'b1);
        drive(1'b0, '0, '0, '0, 1'b0);
        step();
        chk_stat("s2_empty", 1'b0, 2'd0, 1'b1);

        // x0 write suppression
        bus.out_ready = 1'b0;
        drive(1'b1, 32'hDEAD_BEEF, 32'h200, 5'd0, 1'b1);
        step();
        chk_head("s3_x0", 32'hDEAD_BEEF, 32'h200, 5'd0, 1'b0);
        chk_stat("s3_stat", 1'b1, 2'd1, 1'b1);

        // Flush from FULL with concurrent handshakes
        drive(1'b1, 32'h44, 32'h204, 5'd4, 1'b1);
        step();
        chk_stat("s4_full", 1'b1, 2'd2, 1'b0);
        flush = 1'b1;
        bus.out_ready = 1'b1;
        drive(1'b1, 32'h55, 32'h208, 5'd6, 1'b1);
        step();
        flush = 1'b0;
        drive(1'b0, '0, '0, '0, 1'b0);
        chk_stat("s4_flush", 1'b0, 2'd0, 1'b1);
        step();
        chk_stat("s4_after", 1'b0, 2'd0, 1'b1);
        chk_head("s4_hold", 32'hDEAD_BEEF, 32'h200, 5'd0, 1'b0);

        // Asynchronous reset mid-cycle while holding an entry
        bus.out_ready = 1'b0;
        drive(1'b1, 32'h66, 32'h300, 5'd7, 1'b1);
        step();
        chk_stat("s5_one", 1'b1, 2'd1, 1'b1);
        drive(1'b0, '0, '0, '0, 1'b0);
        #3 rst_n = 1'b0;
        #1;
        chk_stat("s5_rst_stat", 1'b0, 2'd0, 1'b1);
        chk_head("s5_rst_head", 32'h0, 32'h0, 5'd0, 1'b0);
        drive(1'b1, 32'h0000_0010, 32'h8000_0000, 5'd5, 1'b1);
        bus.out_ready = 1'b1;
        @(negedge clock);
        rst_n = 1'b1;
        step();
        chk_stat("s5_push_stat", 1'b1, 2'd1, 1'b1);
        chk_head("s5_push_head", 32'h0000_0010, 32'h8000_0000, 5'd5, 1'b1);
        drive(1'b0, '0, '0, '0, 1'b0);
        step();
        chk_stat("rnd_start", 1'b0, 2'd0, 1'b1);

        // Random traffic against a FIFO model
        q.delete();
        for (int cyc = 0; cyc < 10000; cyc++) begin
            int   cnt;
            logic iv;
            logic ordy;
            logic fl;
            ent_t e;
            cnt = q.size();
            chk_stat("rnd_stat", (cnt != 0), 2'(cnt), (cnt != 2));
            if (cnt != 0) begin
                chk_head("rnd_head", q[0].res, q[0].pc, q[0].rd, q[0].wen);
            end
            iv   = ($urandom_range(0, 3) != 0);
            ordy = ($urandom_range(0, 2) != 0);
            fl   = ($urandom_range(0, 63) == 0);
            e.res = $urandom;
            e.pc  = $urandom;
            e.rd  = 5'($urandom_range(0, 31));
            e.wen = ($urandom_range(0, 1) != 0);
            drive(iv, e.res, e.pc, e.rd, e.wen);
            bus.out_ready = ordy;
            flush = fl;
            if (fl) begin
                q.delete();
            end else begin
                if (ordy && cnt != 0) begin
                    void'(q.pop_front());
                end
                if (iv && cnt != 2) begin
                    e.wen = e.wen & (e.rd != 5'd0);
                    q.push_back(e);
                end
            end
            step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
